display_scan_controller: RTL and testbench



---
 rtl/display_scan_controller.sv | 202 ++++++++++++++++++++
 tb/tb_display_scan_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
//
// Time-multiplexes the four microwave timer digits (TenMin, Min, TenSec, Sec)
// onto one shared BCD-to-7-segment decoder and one shared segment bus.
//
// Each digit slot is a BLANK guard (all anodes off, decoder settles on the new
// BcdOut) followed by a DRIVE window (one anode low, decoder output forwarded
// to the pins). All four digits are snapshotted together at the frame boundary
// so a frame never shows a mix of old and new timer values.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   TenMin     BCD tens-of-minutes from the timer
//   Min        BCD minutes
//   TenSec     BCD tens-of-seconds
//   Sec        BCD seconds
//   BlinkEn    1 = flash the whole display
//   SegIn      active-low segments from the shared decoder (abcdefg, MSB = a)
//   BcdOut     BCD digit presented to the shared decoder
//   SegOut     active-low segments to the pins (7'h7F = dark)
//   Anode      active-low digit enables: [3]=TenMin [2]=Min [1]=TenSec [0]=Sec
//   FrameTick  one-cycle pulse at each frame boundary
// -----------------------------------------------------------------------------
module display_scan_controller #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 100,
  parameter bit LZ_SUPPRESS  = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] TenMin,
  input  logic [3:0] Min,
  input  logic [3:0] TenSec,
  input  logic [3:0] Sec,
  input  logic       BlinkEn,
  input  logic [6:0] SegIn,
  output logic [3:0] BcdOut,
  output logic [6:0] SegOut,
  output logic [3:0] Anode,
  output logic       FrameTick
);

  // Shared counter serves both phases, so size it for the longer one.
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BLK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_DARK   = 7'h7F;
  localparam logic [3:0] ANODE_DARK = 4'b1111;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Scan sequencer state
  state_t           state, state_nx;
  logic [1:0]       idx, idx_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             frame_end;

  // Per-frame digit snapshot; index 0 = TenMin .. 3 = Sec
  logic [3:0]       snap [4];

  // Blink bookkeeping
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  // Output decode helpers
  logic [3:0]       cur_bcd;
  logic             visible;

  // ---------------------------------------------------------------------------
  // Sequencer state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= BLANK;
      idx   <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic: BLANK guard then DRIVE window for each digit, Idx
  // advances as DRIVE ends so BcdOut only ever changes on BLANK entry.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    cnt_nx    = cnt + CNT_W'(1);
    frame_end = 1'b0;
    unique case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nx = DRIVE;
          cnt_nx   = '0;
        end
      end
      DRIVE: begin
        if (cnt == SCAN_LAST) begin
          state_nx  = BLANK;
          cnt_nx    = '0;
          idx_nx    = idx + 2'd1;
          frame_end = (idx == 2'd3);
        end
      end
      default: begin
        state_nx = BLANK;
        cnt_nx   = '0;
        idx_nx   = 2'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame boundary: snapshot the timer digits and flag the new frame
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap[0]   <= 4'd0;
      snap[1]   <= 4'd0;
      snap[2]   <= 4'd0;
      snap[3]   <= 4'd0;
      FrameTick <= 1'b0;
    end else begin
      FrameTick <= frame_end;
      if (frame_end) begin
        snap[0] <= TenMin;
        snap[1] <= Min;
        snap[2] <= TenSec;
        snap[3] <= Sec;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Blink phase: counts frames while enabled; clearing while disabled makes a
  // fresh blink request always start in the visible half.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!BlinkEn) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (FrameTick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  assign cur_bcd = snap[idx];
  assign BcdOut  = cur_bcd;

  // Invalid BCD (10..15) is blanked rather than showing decoder garbage.
  always_comb begin
    visible = (state == DRIVE);
    if (BlinkEn && blink_phase) begin
      visible = 1'b0;
    end
    if (LZ_SUPPRESS && (idx == 2'd0) && (snap[0] == 4'd0)) begin
      visible = 1'b0;
    end
    if (cur_bcd > 4'd9) begin
      visible = 1'b0;
    end
  end

  // Idx 0 (TenMin) maps to Anode[3]; at most one anode is ever low.
  always_comb begin
    Anode  = ANODE_DARK;
    SegOut = SEG_DARK;
    if (visible) begin
      SegOut = SegIn;
      unique case (idx)
        2'd0:    Anode = 4'b0111;
        2'd1:    Anode = 4'b1011;
        2'd2:    Anode = 4'b1101;
        default: Anode = 4'b1110;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

  localparam int SD  = 4;
  localparam int BC  = 1;
  localparam int BF  = 2;
  localparam int SLOT = BC + SD;
  localparam int FL  = 4 * SLOT;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] TenMin, Min, TenSec, Sec;
  logic       BlinkEn;
  logic [6:0] SegIn;
  logic [3:0] BcdOut;
  logic [6:0] SegOut;
  logic [3:0] Anode;
  logic       FrameTick;

  display_scan_controller #(
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF),
    .LZ_SUPPRESS (1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .TenMin   (TenMin),
    .Min      (Min),
    .TenSec   (TenSec),
    .Sec      (Sec),
    .BlinkEn  (BlinkEn),
    .SegIn    (SegIn),
    .BcdOut   (BcdOut),
    .SegOut   (SegOut),
    .Anode    (Anode),
    .FrameTick(FrameTick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] bcd;
    logic       ft;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  // Reference model state (frame position arithmetic, not a state machine)
  int         t;
  logic [3:0] snap_m [4];
  int         bcnt_m;
  logic       phase_m;
  logic       tick_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < 4; i++) snap_m[i] = 4'd0;
    bcnt_m  = 0;
    phase_m = 1'b0;
    tick_m  = 1'b0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   pos, d, sub;
    logic vis;
    pos = t % FL;
    d   = pos / SLOT;
    sub = pos % SLOT;
    e.bcd = snap_m[d];
    vis = (sub >= BC);
    if (BlinkEn && phase_m) vis = 1'b0;
    if (d == 0 && snap_m[0] == 4'd0) vis = 1'b0;
    if (snap_m[d] > 4'd9) vis = 1'b0;
    e.an  = vis ? ~(4'b1000 >> d) : 4'b1111;
    e.seg = vis ? SegIn : 7'h7F;
    e.ft  = tick_m;
    return e;
  endfunction

  // One clock: advance model across the edge, drive fresh SegIn, push the
  // expectation, then pop and compare against the DUT.
  task automatic step(input int n);
    exp_t e, g;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (!BlinkEn) begin
        bcnt_m  = 0;
        phase_m = 1'b0;
      end else if (tick_m) begin
        if (bcnt_m == BF - 1) begin
          bcnt_m  = 0;
          phase_m = ~phase_m;
        end else begin
          bcnt_m++;
        end
      end
      tick_m = ((t % FL) == FL - 1);
      if (tick_m) begin
        snap_m[0] = TenMin;
        snap_m[1] = Min;
        snap_m[2] = TenSec;
        snap_m[3] = Sec;
      end
      t++;
      #1;
      SegIn = 7'($urandom);
      #1;
      e = model_out();
      sb.push_back(e);
      g = sb.pop_front();
      check("anode",     {28'd0, Anode},     {28'd0, g.an});
      check("segout",    {25'd0, SegOut},    {25'd0, g.seg});
      check("bcdout",    {28'd0, BcdOut},    {28'd0, g.bcd});
      check("frametick", {31'd0, FrameTick}, {31'd0, g.ft});
    end
  endtask

  initial begin
    int guard;
    reset_n = 1'b0;
    BlinkEn = 1'b0;
    SegIn   = 7'h2A;
    TenMin  = 4'd1;
    Min     = 4'd2;
    TenSec  = 4'd3;
    Sec     = 4'd4;
    model_reset();

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #2;
    check("rst_anode",  {28'd0, Anode},     32'hF);
    check("rst_segout", {25'd0, SegOut},    32'h7F);
    check("rst_bcd",    {28'd0, BcdOut},    32'h0);
    check("rst_ft",     {31'd0, FrameTick}, 32'h0);
    #2 reset_n = 1'b1;
    model_reset();

    // Frame 1 shows zeros (TenMin suppressed), frame 2 shows 1,2,3,4
    step(2 * FL);

    // Mid-frame Sec change waits for the next boundary
    step(7);
    Sec = 4'd7;
    step(FL + 5);

    // Leading-zero suppression with TenSec = 0 still shown
    TenMin = 4'd0; Min = 4'd5; TenSec = 4'd0; Sec = 4'd9;
    step(2 * FL);

    // Invalid BCD in one digit only
    TenMin = 4'd2; TenSec = 4'hC;
    step(2 * FL);
    TenSec = 4'd3;

    // Blink over several frames
    BlinkEn = 1'b1;
    step(6 * FL);
    // Drop BlinkEn part-way into a dark phase
    guard = 0;
    while (!(phase_m && (t % FL) == 7) && guard < 10 * FL) begin
      step(1);
      guard++;
    end
    check("blink_dark_reached", {31'd0, phase_m}, 32'd1);
    BlinkEn = 1'b0;
    step(FL);

    // Reset mid-DRIVE of Idx2
    guard = 0;
    while (!((t % FL) / SLOT == 2 && (t % SLOT) == BC + 1) && guard < 2 * FL) begin
      step(1);
      guard++;
    end
    check("idx2_drive_reached", {28'd0, Anode}, 32'hD);
    reset_n = 1'b0;
    #1;
    check("async_anode",  {28'd0, Anode},  32'hF);
    check("async_segout", {25'd0, SegOut}, 32'h7F);
    check("async_bcd",    {28'd0, BcdOut}, 32'h0);
    #1 reset_n = 1'b1;
    model_reset();
    step(FL + SLOT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "timeout");
  end

endmodule
